// File: rtl/pht_gshare_if.sv
`default_nettype none
// ============================================================================
// Module   : pht_gshare_if
// Brief    : Lookup/update bundle between a branch-history tracker and the
//            gshare pattern history table. Stats signals exist only when
//            PHT_GSHARE_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
interface pht_gshare_if #(
    parameter int IWIDTH = 6,
    parameter int HWIDTH = 6
);
    logic              en;
    logic              do_update;
    logic              last_taken;
    logic [IWIDTH-1:0] index;
    logic [HWIDTH-1:0] history;
    logic              pred_taken;
    logic              pred_strong;
    logic              mispredict;
`ifdef PHT_GSHARE_STATS_EN
    logic [31:0]       stat_updates;
    logic [31:0]       stat_mispredicts;
`endif

    modport master (
        output en, do_update, last_taken, index, history,
`ifdef PHT_GSHARE_STATS_EN
        input  stat_updates, stat_mispredicts,
`endif
        input  pred_taken, pred_strong, mispredict
    );

    modport slave (
        input  en, do_update, last_taken, index, history,
`ifdef PHT_GSHARE_STATS_EN
        output stat_updates, stat_mispredicts,
`endif
        output pred_taken, pred_strong, mispredict
    );
endinterface
`default_nettype wire

// File: rtl/pht_gshare.sv
`default_nettype none
// ============================================================================
// Module   : pht_gshare
// Brief    : Gshare pattern history table with deferred update and bypass.
//            Optional PHT_GSHARE_STATS_EN adds update/mispredict counters.
// Revision : 1.0
// ============================================================================
module pht_gshare #(
    parameter int IWIDTH = 6,
    parameter int HWIDTH = 6,
    parameter int CWIDTH = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pht_gshare_if.slave       bus
);
    localparam int                DEPTH   = 1 << IWIDTH;
    localparam logic [CWIDTH-1:0] CTR_MAX = '1;
    localparam logic [CWIDTH-1:0] CTR_MIN = '0;
    localparam logic [CWIDTH-1:0] WEAK_NT = {1'b0, {(CWIDTH-1){1'b1}}};

    generate
        if (HWIDTH > IWIDTH) begin : g_bad_hwidth
            $error("pht_gshare: HWIDTH must not exceed IWIDTH");
        end
        if (CWIDTH < 2) begin : g_bad_cwidth
            $error("pht_gshare: CWIDTH must be at least 2");
        end
    endgenerate

    logic [CWIDTH-1:0] ctr_q [DEPTH];
    logic [CWIDTH-1:0] ctr_d [DEPTH];
    logic [IWIDTH-1:0] last_tidx_q, last_tidx_d;
    logic              last_pred_q, last_pred_d;

    logic [IWIDTH-1:0] hist_ext;
    logic [IWIDTH-1:0] tidx;
    logic              upd_fire;
    logic [CWIDTH-1:0] upd_cur;
    logic [CWIDTH-1:0] upd_val;
    logic [CWIDTH-1:0] look_val;

    always_comb begin
        hist_ext               = '0;
        hist_ext[HWIDTH-1:0]   = bus.history;
        tidx                   = bus.index ^ hist_ext;
        upd_fire               = bus.en && bus.do_update;
        upd_cur                = ctr_q[last_tidx_q];
        upd_val                = upd_cur;
        if (bus.last_taken) begin
            if (upd_cur != CTR_MAX) upd_val = upd_cur + 1'b1;
        end else begin
            if (upd_cur != CTR_MIN) upd_val = upd_cur - 1'b1;
        end
        // A lookup of the entry being written this cycle sees the new value.
        look_val = (upd_fire && (tidx == last_tidx_q)) ? upd_val : ctr_q[tidx];
    end

    assign bus.pred_taken  = look_val[CWIDTH-1];
    assign bus.pred_strong = (look_val == CTR_MAX) || (look_val == CTR_MIN);
    assign bus.mispredict  = upd_fire && (last_pred_q != bus.last_taken);

    always_comb begin
        ctr_d       = ctr_q;
        last_tidx_d = last_tidx_q;
        last_pred_d = last_pred_q;
        if (upd_fire) ctr_d[last_tidx_q] = upd_val;
        if (bus.en) begin
            last_tidx_d = tidx;
            last_pred_d = bus.pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= WEAK_NT;
            last_tidx_q <= '0;
            last_pred_q <= 1'b0;
        end else begin
            ctr_q       <= ctr_d;
            last_tidx_q <= last_tidx_d;
            last_pred_q <= last_pred_d;
        end
    end

`ifdef PHT_GSHARE_STATS_EN
    logic [31:0] stat_upd_q, stat_upd_d;
    logic [31:0] stat_mp_q,  stat_mp_d;

    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mp_d  = stat_mp_q;
        if (upd_fire) begin
            if (stat_upd_q != 32'hFFFF_FFFF) stat_upd_d = stat_upd_q + 32'd1;
            if (bus.mispredict && (stat_mp_q != 32'hFFFF_FFFF))
                stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_upd_q <= '0;
            stat_mp_q  <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mp_q  <= stat_mp_d;
        end
    end

    assign bus.stat_updates     = stat_upd_q;
    assign bus.stat_mispredicts = stat_mp_q;
`endif
endmodule
`default_nettype wire
